// File: rtl/rx_byte_fifo.sv
// rx_byte_fifo: byte FIFO fed by a serial receiver running on another clock.
// The receiver's byte-valid level is synchronised and edge-detected; each rising
// edge writes one byte (or counts a parity error). Reads are synchronous with
// registered data out.
`timescale 1ns/1ps

module rx_byte_fifo #(
  parameter int DEPTH = 8,
  parameter int CW    = 4
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic [7:0]    PDin,
  input  logic          PDready_in,
  input  logic          ParErr_in,
  input  logic          Rd_en,
  input  logic          Clr,
  output logic [7:0]    Dout,
  output logic          Empty,
  output logic          Full,
  output logic [CW-1:0] Count,
  output logic          Overflow,
  output logic [7:0]    ErrCnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic          s1, s2, s3;
  logic          wr_evt;
  logic          rd_acc;
  logic          wr_acc;
  logic          ovf_evt;
  logic          err_evt;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [7:0]    mem [DEPTH];

  // Status flags follow Count directly so reset clears them immediately
  assign Empty = (Count == '0);
  assign Full  = (Count == CW'(DEPTH));

  assign wr_evt  = s2 & ~s3;
  assign rd_acc  = Rd_en & ~Empty;
  // A full FIFO still accepts a good byte when a read frees a slot on the same edge
  assign wr_acc  = wr_evt & ~ParErr_in & (~Full | rd_acc);
  assign ovf_evt = wr_evt & ~ParErr_in & Full & ~rd_acc;
  assign err_evt = wr_evt & ParErr_in;

  // Two-flop synchroniser plus history flop for rising-edge detection
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= PDready_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Storage array; never reset, only reachable through an accepted read
  always_ff @(posedge Clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= PDin;
    end
  end

  // Pointers, occupancy and registered read data
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      Count  <= '0;
      Dout   <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + AW'(1);
        Dout   <= mem[rd_ptr];
      end
      case ({wr_acc, rd_acc})
        2'b10:   Count <= Count + CW'(1);
        2'b01:   Count <= Count - CW'(1);
        default: Count <= Count;
      endcase
    end
  end

  // Sticky overflow flag and saturating parity-error counter; Clr wins
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Overflow <= 1'b0;
      ErrCnt   <= '0;
    end else if (Clr) begin
      Overflow <= 1'b0;
      ErrCnt   <= '0;
    end else begin
      if (ovf_evt) begin
        Overflow <= 1'b1;
      end
      if (err_evt && (ErrCnt != '1)) begin
        ErrCnt <= ErrCnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_rx_byte_fifo.sv
// Self-checking bench for rx_byte_fifo: a queue-based reference model tracks
// stored bytes, last read value, overflow and error count per handled edge.
`timescale 1ns/1ps

module tb_rx_byte_fifo;

  localparam int DEPTH = 8;
  localparam int CW    = 4;
  localparam int VW    = 8 + CW + 3 + 8;

  logic          Clk;
  logic          Rst_n;
  logic [7:0]    PDin;
  logic          PDready_in;
  logic          ParErr_in;
  logic          Rd_en;
  logic          Clr;
  logic [7:0]    Dout;
  logic          Empty;
  logic          Full;
  logic [CW-1:0] Count;
  logic          Overflow;
  logic [7:0]    ErrCnt;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [7:0] q[$];
  logic [7:0] m_dout;
  bit         m_ovf;
  int         m_err;

  logic [VW-1:0] act_vec;
  assign act_vec = {Dout, Count, Empty, Full, Overflow, ErrCnt};

  rx_byte_fifo #(.DEPTH(DEPTH), .CW(CW)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .PDin      (PDin),
    .PDready_in(PDready_in),
    .ParErr_in (ParErr_in),
    .Rd_en     (Rd_en),
    .Clr       (Clr),
    .Dout      (Dout),
    .Empty     (Empty),
    .Full      (Full),
    .Count     (Count),
    .Overflow  (Overflow),
    .ErrCnt    (ErrCnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [VW-1:0] exp_vec();
    return {m_dout, CW'(q.size()), (q.size() == 0), (q.size() == DEPTH), m_ovf, 8'(m_err)};
  endfunction

  task automatic model_reset();
    q.delete();
    m_dout = 8'h00;
    m_ovf  = 1'b0;
    m_err  = 0;
  endtask

  // One handled clock edge as described by the FIFO rules
  task automatic model_edge(input bit rd, input bit wr, input logic [7:0] d,
                            input bit pe, input bit clr);
    bit racc;
    bit was_full;
    racc     = rd && (q.size() > 0);
    was_full = (q.size() == DEPTH);
    if (racc) m_dout = q.pop_front();
    if (wr) begin
      if (pe) begin
        if (!clr && m_err < 255) m_err++;
      end else if (!was_full || racc) begin
        q.push_back(d);
      end else if (!clr) begin
        m_ovf = 1'b1;
      end
    end
    if (clr) begin
      m_ovf = 1'b0;
      m_err = 0;
    end
  endtask

  // Starts and ends just after a falling edge. PDready_in held for 4 edges;
  // the byte is handled on the third edge, where rd/clr are applied too.
  task automatic send_byte(input logic [7:0] d, input bit pe, input bit rd, input bit clr);
    PDin = d; ParErr_in = pe; PDready_in = 1'b1;
    @(posedge Clk); @(negedge Clk);
    @(posedge Clk); @(negedge Clk);
    Rd_en = rd; Clr = clr;
    @(posedge Clk);
    model_edge(rd, 1'b1, d, pe, clr);
    @(negedge Clk);
    Rd_en = 1'b0; Clr = 1'b0;
    @(posedge Clk); @(negedge Clk);
    PDready_in = 1'b0;
    repeat (3) @(negedge Clk);
  endtask

  task automatic do_read();
    Rd_en = 1'b1;
    @(posedge Clk);
    model_edge(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge Clk);
    Rd_en = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    total++;
    if (act_vec !== exp_vec()) begin
      bad++;
      $display("FAIL reset_state: got %h expected %h", act_vec, exp_vec());
    end
  endtask

  task automatic test_single();
    PDin = 8'hA5; ParErr_in = 1'b0; PDready_in = 1'b1;
    @(posedge Clk); @(negedge Clk);
    @(posedge Clk); @(negedge Clk);
    total++;
    if (Count !== CW'(0)) begin
      bad++;
      $display("FAIL single_latency_n1: Count got %0d expected 0", Count);
    end
    @(posedge Clk);
    model_edge(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0);
    @(negedge Clk);
    total++;
    if (Count !== CW'(1) || Empty !== 1'b0) begin
      bad++;
      $display("FAIL single_write_n2: Count=%0d Empty=%b expected 1/0", Count, Empty);
    end
    @(posedge Clk); @(negedge Clk);
    PDready_in = 1'b0;
    repeat (3) @(negedge Clk);
    total++;
    if (Count !== CW'(1)) begin
      bad++;
      $display("FAIL single_no_repeat: Count got %0d expected 1", Count);
    end
    do_read();
    total++;
    if (Dout !== 8'hA5 || Count !== CW'(0) || Empty !== 1'b1) begin
      bad++;
      $display("FAIL single_read: Dout=%h Count=%0d Empty=%b expected a5/0/1", Dout, Count, Empty);
    end
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= 9; i++) begin
      send_byte(8'(i), 1'b0, 1'b0, 1'b0);
      if (i == 8) begin
        total++;
        if (Full !== 1'b1 || Count !== CW'(8)) begin
          bad++;
          $display("FAIL fill_full: Full=%b Count=%0d expected 1/8", Full, Count);
        end
      end
    end
    total++;
    if (Overflow !== 1'b1 || Count !== CW'(8)) begin
      bad++;
      $display("FAIL fill_overflow: Overflow=%b Count=%0d expected 1/8", Overflow, Count);
    end
    for (int i = 1; i <= 8; i++) begin
      do_read();
      total++;
      if (Dout !== 8'(i)) begin
        bad++;
        $display("FAIL fill_read_%0d: Dout got %h expected %h", i, Dout, 8'(i));
      end
    end
    total++;
    if (act_vec !== exp_vec()) begin
      bad++;
      $display("FAIL fill_final: got %h expected %h", act_vec, exp_vec());
    end
  endtask

  task automatic test_parity();
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b1, 1'b0, 1'b0);
    total++;
    if (ErrCnt !== 8'd3 || Count !== CW'(0)) begin
      bad++;
      $display("FAIL parity_three: ErrCnt=%0d Count=%0d expected 3/0", ErrCnt, Count);
    end
    for (int i = 3; i < 260; i++) send_byte(8'($urandom), 1'b1, 1'b0, 1'b0);
    total++;
    if (ErrCnt !== 8'd255 || Count !== CW'(0)) begin
      bad++;
      $display("FAIL parity_saturate: ErrCnt=%0d Count=%0d expected 255/0", ErrCnt, Count);
    end
    Clr = 1'b1;
    @(posedge Clk);
    model_edge(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    @(negedge Clk);
    Clr = 1'b0;
    total++;
    if (ErrCnt !== 8'd0 || Overflow !== 1'b0) begin
      bad++;
      $display("FAIL parity_clr: ErrCnt=%0d Overflow=%b expected 0/0", ErrCnt, Overflow);
    end
  endtask

  task automatic test_clr_priority();
    for (int i = 0; i < DEPTH; i++) send_byte(8'($urandom), 1'b0, 1'b0, 1'b0);
    send_byte(8'hEE, 1'b0, 1'b0, 1'b1);
    total++;
    if (Overflow !== 1'b0 || Count !== CW'(DEPTH)) begin
      bad++;
      $display("FAIL clr_prio_ovf: Overflow=%b Count=%0d expected 0/%0d", Overflow, Count, DEPTH);
    end
    send_byte(8'h11, 1'b1, 1'b0, 1'b1);
    total++;
    if (ErrCnt !== 8'd0) begin
      bad++;
      $display("FAIL clr_prio_err: ErrCnt got %0d expected 0", ErrCnt);
    end
    for (int i = 0; i < DEPTH; i++) begin
      do_read();
      total++;
      if (act_vec !== exp_vec()) begin
        bad++;
        $display("FAIL clr_prio_drain_%0d: got %h expected %h", i, act_vec, exp_vec());
      end
    end
  endtask

  task automatic test_wrap_concurrency();
    bit saw_full;
    saw_full = 1'b0;
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      send_byte(8'($urandom), 1'b0, 1'b1, 1'b0);
      if (Full) saw_full = 1'b1;
      total++;
      if (Count !== CW'(5) || Dout !== m_dout) begin
        bad++;
        $display("FAIL wrap_step_%0d: Count=%0d Dout=%h expected 5/%h", i, Count, Dout, m_dout);
      end
    end
    total++;
    if (saw_full !== 1'b0) begin
      bad++;
      $display("FAIL wrap_full_seen: Full observed 1 expected 0");
    end
    for (int i = 0; i < 5; i++) begin
      do_read();
      total++;
      if (act_vec !== exp_vec()) begin
        bad++;
        $display("FAIL wrap_drain_%0d: got %h expected %h", i, act_vec, exp_vec());
      end
    end
  endtask

  task automatic test_empty_edge();
    logic [7:0] held;
    held = m_dout;
    Rd_en = 1'b1;
    repeat (4) begin
      @(posedge Clk);
      model_edge(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    end
    @(negedge Clk);
    Rd_en = 1'b0;
    total++;
    if (Dout !== held || Count !== CW'(0) || Empty !== 1'b1) begin
      bad++;
      $display("FAIL empty_rd: Dout=%h Count=%0d Empty=%b expected %h/0/1", Dout, Count, Empty, held);
    end
    send_byte(8'h5A, 1'b0, 1'b1, 1'b0);
    total++;
    if (Count !== CW'(1) || Dout !== held) begin
      bad++;
      $display("FAIL empty_wr_rd: Count=%0d Dout=%h expected 1/%h", Count, Dout, held);
    end
    do_read();
    total++;
    if (Dout !== 8'h5A || Empty !== 1'b1) begin
      bad++;
      $display("FAIL empty_drain: Dout=%h Empty=%b expected 5a/1", Dout, Empty);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 3) == 3) begin
        do_read();
      end else begin
        send_byte(8'($urandom), ($urandom_range(0, 5) == 0), $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 15) == 0));
      end
      total++;
      if (act_vec !== exp_vec()) begin
        bad++;
        $display("FAIL random_%0d: got %h expected %h", i, act_vec, exp_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    while (q.size() > 0) do_read();
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b0, 1'b0, 1'b0);
    send_byte(8'h77, 1'b1, 1'b0, 1'b0);
    do_read();
    send_byte(8'($urandom), 1'b0, 1'b0, 1'b0);
    total++;
    if (Count !== CW'(4)) begin
      bad++;
      $display("FAIL areset_pre: Count got %0d expected 4", Count);
    end
    #2 Rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (act_vec !== exp_vec()) begin
      bad++;
      $display("FAIL areset_immediate: got %h expected %h", act_vec, exp_vec());
    end
    @(negedge Clk);
    Rst_n = 1'b1;
  endtask

  task automatic test_reset_during_pulse();
    @(negedge Clk);
    PDin = 8'h3C; ParErr_in = 1'b0; PDready_in = 1'b1;
    @(posedge Clk); @(negedge Clk);
    Rst_n = 1'b0;
    model_reset();
    @(negedge Clk);
    Rst_n = 1'b1;
    @(posedge Clk); @(negedge Clk);
    @(posedge Clk); @(negedge Clk);
    total++;
    if (Count !== CW'(0)) begin
      bad++;
      $display("FAIL rst_pulse_latency: Count got %0d expected 0", Count);
    end
    @(posedge Clk);
    model_edge(1'b0, 1'b1, 8'h3C, 1'b0, 1'b0);
    repeat (6) @(negedge Clk);
    total++;
    if (Count !== CW'(1)) begin
      bad++;
      $display("FAIL rst_pulse_once: Count got %0d expected 1", Count);
    end
    PDready_in = 1'b0;
    repeat (3) @(negedge Clk);
    do_read();
    total++;
    if (act_vec !== exp_vec() || Dout !== 8'h3C) begin
      bad++;
      $display("FAIL rst_pulse_read: got %h expected %h", act_vec, exp_vec());
    end
  endtask

  initial begin
    Rst_n = 1'b0; PDin = 8'h00; PDready_in = 1'b0; ParErr_in = 1'b0;
    Rd_en = 1'b0; Clr = 1'b0;
    repeat (2) @(negedge Clk);
    test_reset();
    Rst_n = 1'b1;
    repeat (2) @(negedge Clk);
    test_single();
    test_fill_overflow();
    test_parity();
    test_clr_priority();
    test_wrap_concurrency();
    test_empty_edge();
    test_random();
    test_async_reset();
    test_reset_during_pulse();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rx_byte_fifo.md
RX_BYTE_FIFO -- requirements
Module: rx_byte_fifo

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entries; SHALL be a power of two, 2..64.
REQ-002 Parameter CW, default 4, width of Count; SHALL equal log2(DEPTH)+1.
REQ-003 Clk  input  1  sole clock; all state SHALL change on its rising edge.
REQ-004 Rst_n  input  1  reset; asynchronous assert, active-low, released synchronously by the driving logic.
REQ-005 PDin  input  8  parallel byte from the serial receiver's PDout; SHALL be held stable for at least 4 Clk cycles after PDready_in rises.
REQ-006 PDready_in  input  1  receiver byte-valid level, asynchronous to Clk (receiver runs on SoClk).
REQ-007 ParErr_in  input  1  receiver parity error for the current byte; same stability rule as PDin.
REQ-008 Rd_en  input  1  synchronous read request.
REQ-009 Clr  input  1  synchronous clear of Overflow and ErrCnt.
REQ-010 Dout  output  8  registered read data.
REQ-011 Empty, Full  output  1 each  FIFO status, derived from Count.
REQ-012 Count  output  CW  number of stored bytes, 0..DEPTH.
REQ-013 Overflow  output  1  sticky: a good byte was dropped because the FIFO was full.
REQ-014 ErrCnt  output  8  saturating count of bytes rejected for parity error.

Function
REQ-015 PDready_in SHALL pass through a 2-flop synchronizer (s1, s2) followed by a history flop s3; write strobe wr_evt = s2 & ~s3.
REQ-016 Latency: PDready_in first sampled high at edge N -> byte handled at edge N+2, with Count/Full/Empty valid after edge N+2.
REQ-017 One wr_evt per PDready_in rising edge; a level held high SHALL NOT produce repeated writes.
REQ-018 On wr_evt with ParErr_in=1: byte discarded, ErrCnt increments, saturating at 255; FIFO unchanged.
REQ-019 On wr_evt with ParErr_in=0 and (not Full or read accepted same edge): PDin written at the write pointer; write pointer advances modulo DEPTH.
REQ-020 On wr_evt with ParErr_in=0, Full, and no accepted read: byte dropped, Overflow set to 1 and held.
REQ-021 Read accepted iff Rd_en=1 and Empty=0: Dout loads the head entry at that edge; read pointer advances modulo DEPTH.
REQ-022 Rd_en while Empty: ignored; Dout, pointers and Count unchanged; no error flag.
REQ-023 Simultaneous accepted write and read: Count unchanged. Write only: Count+1. Read only: Count-1.
REQ-024 Empty with simultaneous good write and Rd_en: write accepted, read ignored (no bypass).
REQ-025 Pointers SHALL wrap from DEPTH-1 to 0 with no lost or duplicated entries.
REQ-026 Dout SHALL hold its last read value until the next accepted read.
REQ-027 Clr=1: Overflow<=0 and ErrCnt<=0; FIFO contents, pointers and Count unaffected.
REQ-028 Clr has priority: an overflow or parity event on the same edge as Clr SHALL NOT be recorded.

Reset
REQ-029 Rst_n=0 SHALL immediately force s1..s3=0, pointers=0, Count=0, Empty=1, Full=0, Dout=8'h00, Overflow=0, ErrCnt=0.
REQ-030 Storage array contents need not be reset; reset SHALL never expose them on Dout.
REQ-031 Reset during a PDready_in high pulse: after release, the still-high level SHALL yield at most one write, following REQ-016 timing.

Verification
REQ-032 Single byte: PDin=8'hA5, ParErr_in=0, pulse PDready_in 4 cycles -> Count 0->1 at edge N+2, Empty=0; Rd_en 1 cycle -> Dout=8'hA5, Count=0, Empty=1.
REQ-033 Fill/overflow: 9 good bytes 8'h01..8'h09, no reads -> Full=1 after 8th, 9th dropped, Overflow=1; 8 reads return 8'h01..8'h08 in order.
REQ-034 Parity: 3 bytes with ParErr_in=1 -> ErrCnt=3, Count=0; 260 such bytes -> ErrCnt=255; Clr -> ErrCnt=0, Overflow=0.
REQ-035 Wrap and concurrency: 20 bytes with a read on every write edge once Count=5 -> output order exact, Count stays 5, Full never set.
REQ-036 Empty edge: Rd_en held high while Empty -> Dout unchanged; good byte then Rd_en on its write edge -> Count=1, Dout unchanged.
REQ-037 Async reset: assert Rst_n=0 mid-stream with Count=4 -> all outputs at REQ-029 values before the next Clk edge.
